// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback cycles, stalling on the memory ready handshake.
module multicycle_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    ctrl_t      c, c_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) opcode_q <= opcode;
        end
    end

    // Memory handshake: mem_read/mem_write are levels held by the FSM; the
    // access completes in the cycle mem_ready is high, otherwise the state holds.
    always_comb begin
        c       = '0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                state_d     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        c.illegal_op = 1'b1;
                        c.instr_done = 1'b1;
                        state_d      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                state_d     = (opcode_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                state_d    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = mem_ready;
                state_d      = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_src     = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset masks every output so nothing half-issued leaks out mid-instruction.
    assign c_out      = reset ? '0 : c;
    assign state      = reset ? 4'd0 : state_q;
    assign pc_write   = c_out.pc_write;
    assign branch     = c_out.branch;
    assign iord       = c_out.iord;
    assign mem_read   = c_out.mem_read;
    assign mem_write  = c_out.mem_write;
    assign ir_write   = c_out.ir_write;
    assign reg_dst    = c_out.reg_dst;
    assign mem_to_reg = c_out.mem_to_reg;
    assign reg_write  = c_out.reg_write;
    assign alu_src_a  = c_out.alu_src_a;
    assign alu_src_b  = c_out.alu_src_b;
    assign pc_src     = c_out.pc_src;
    assign alu_op     = c_out.alu_op;
    assign instr_done = c_out.instr_done;
    assign illegal_op = c_out.illegal_op;

endmodule
